// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's request/response bundle for alu_arbiter
//   valid/ready      request handshake (ready is a one-cycle accept pulse)
//   lock             keep ALU ownership for this requester's next request
//   opcode, x, y     ALU operation and operands, sampled on accept
//   resp_valid/ready response handshake
//   result, cf       captured ALU result and carry/compare flag
//   master = requester side, slave = arbiter side
interface alu_arbiter_if #(parameter int DATA_W = 16);
  logic valid, ready, lock, resp_valid, resp_ready, cf;
  logic [2:0] opcode;
  logic [DATA_W-1:0] x, y, result;
  modport master(output valid, lock, opcode, x, y, resp_ready, input ready, resp_valid, result, cf);
  modport slave(input valid, lock, opcode, x, y, resp_ready, output ready, resp_valid, result, cf);
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters with lock support
//   CLK, RST           clock, synchronous active-high reset
//   r0, r1             requester bundles (alu_arbiter_if.slave)
//   alu_enable, alu_opcode, alu_x, alu_y   ALU issue, zero while not issuing
//   alu_results, alu_cf                    ALU outputs, one cycle after issue
//   busy               high whenever the FSM is not in IDLE
//   ALU_ARB_RR_EN      defined: round-robin on ties; undefined: r0 wins ties
module alu_arbiter #(parameter int DATA_W = 16) (
  input  logic              CLK,
  input  logic              RST,
  alu_arbiter_if.slave      r0,
  alu_arbiter_if.slave      r1,
  output logic              alu_enable,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_results,
  input  logic              alu_cf,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_nxt;
  logic gnt, sel, e0, e1, acc, lock_set, lock_id;
  logic [2:0] op_q;
  logic [DATA_W-1:0] x_q, y_q;
  logic [1:0][DATA_W-1:0] res_q;
  logic [1:0] cf_q;
  // a held lock makes the non-owner ineligible
  assign e0 = r0.valid && !(lock_set && lock_id);
  assign e1 = r1.valid && !(lock_set && !lock_id);
`ifdef ALU_ARB_RR_EN
  logic last_grant;
  assign sel = (e0 && e1) ? !last_grant : e1;
  always_ff @(posedge CLK)
    if (RST) last_grant <= 1'b1;
    else if (acc) last_grant <= sel;
`else
  assign sel = !e0;
`endif
  always_comb begin
    state_nxt = state;
    acc = 1'b0;
    case (state)
      IDLE: begin
        acc = !RST && (e0 || e1);
        state_nxt = acc ? ISSUE : IDLE;
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = (gnt ? r1.resp_ready : r0.resp_ready) ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // only the granted requester can be granted while locked, so a granted
  // lock=0 always comes from the owner (or no lock is held) and clears it
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt <= 1'b0;
      op_q <= '0;
      x_q <= '0;
      y_q <= '0;
      lock_set <= 1'b0;
      lock_id <= 1'b0;
      res_q <= '0;
      cf_q <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        gnt <= sel;
        op_q <= sel ? r1.opcode : r0.opcode;
        x_q <= sel ? r1.x : r0.x;
        y_q <= sel ? r1.y : r0.y;
        lock_set <= sel ? r1.lock : r0.lock;
        lock_id <= sel;
      end
      if (state == CAPTURE) begin
        res_q[gnt] <= alu_results;
        cf_q[gnt] <= alu_cf;
      end
    end
  end
  assign r0.ready = acc && !sel;
  assign r1.ready = acc && sel;
  assign r0.resp_valid = state == RESP && !gnt;
  assign r1.resp_valid = state == RESP && gnt;
  assign r0.result = res_q[0];
  assign r1.result = res_q[1];
  assign r0.cf = cf_q[0];
  assign r1.cf = cf_q[1];
  assign alu_enable = state == ISSUE;
  assign alu_opcode = alu_enable ? op_q : '0;
  assign alu_x = alu_enable ? x_q : '0;
  assign alu_y = alu_enable ? y_q : '0;
  assign busy = state != IDLE;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width; SHALL match the shared ALU datapath width.
REQ-002 CLK  input  1  clock; all state SHALL update on rising edge only.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 rN_valid  input  1  request from requester N (N=0,1; each rN_ port SHALL exist for N=0 and N=1).
REQ-005 rN_ready  output  1  one-cycle pulse: request of N accepted this cycle.
REQ-006 rN_lock  input  1  sampled with the request; 1 = keep ALU ownership for N's next request.
REQ-007 rN_opcode  input  3  ALU opcode for requester N.
REQ-008 rN_x, rN_y  input  DATA_W  operands for requester N.
REQ-009 rN_resp_valid  output  1  response for N available.
REQ-010 rN_resp_ready  input  1  requester N consumes response.
REQ-011 rN_result  output  DATA_W  captured ALU result; rN_cf  output  1  captured carry/compare flag.
REQ-012 alu_enable  output  1  ALU Enable; alu_opcode  output  3; alu_x, alu_y  output  DATA_W.
REQ-013 alu_results  input  DATA_W; alu_cf  input  1  registered ALU outputs (1-cycle latency).
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP.
REQ-016 IDLE: if any eligible rN_valid, SHALL select grant, latch opcode/x/y/lock into internal regs, pulse rN_ready for one cycle, go ISSUE; else stay IDLE.
REQ-017 ISSUE: SHALL drive alu_enable=1 with latched opcode/x/y for exactly one cycle, go CAPTURE.
REQ-018 CAPTURE: SHALL latch alu_results/alu_cf into the granted requester's rN_result/rN_cf, go RESP.
REQ-019 RESP: SHALL hold rN_resp_valid=1 with stable result/cf until rN_resp_ready=1; on that cycle go IDLE.
REQ-020 Request-acceptance-to-resp_valid latency SHALL be exactly 3 cycles; back-to-back throughput one op per 4 cycles minimum.
REQ-021 alu_enable SHALL be 0 in IDLE, CAPTURE, RESP; alu_opcode/alu_x/alu_y SHALL be 0 when alu_enable=0.
REQ-022 Only the granted requester's resp_valid SHALL ever be high; rN_ready SHALL never assert outside IDLE.
REQ-023 Lock: granted request with lock=1 SHALL set lock_owner=N; granted request from owner with lock=0 SHALL clear it.
REQ-024 While lock_owner is set, only the owner is eligible; other requester SHALL wait regardless of arbitration mode (protects ALU accumulator ops, opcode 101).
REQ-025 Requester inputs other than rN_valid/rN_resp_ready SHALL be ignored outside the acceptance cycle.
REQ-026 rN_valid dropping before acceptance SHALL withdraw the request with no side effect.

Reset
REQ-027 RST=1 SHALL force state IDLE, lock_owner clear, last_grant=1 (so r0 wins first tie), all outputs 0 (incl. result/cf regs) on the next edge.
REQ-028 RST in any state SHALL abort the operation in flight; no resp_valid for the aborted op SHALL appear.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: both eligible in IDLE -> grant requester not equal to last_grant; last_grant updates on every grant.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, r0 SHALL win every tie; lock rules (REQ-023/024) unchanged.

Verification
REQ-031 Reset, r0 opcode 001 x=FFFF y=0001 -> r0_ready pulse, alu_enable 1 cycle later, r0_resp_valid 3 cycles after accept with r0_result=0000, r0_cf=1.
REQ-032 r0 and r1 valid together continuously, opcode 010 -> RR build: grants r0,r1,r0,r1; fixed build: grants r0,r0,r0.
REQ-033 r1 lock=1 op 001 x=0003 y=0004, then op 101 y=0002 lock=0, r0 valid throughout -> r0 not granted until after r1's second op; r1 results 0007 then 0009.
REQ-034 r0_resp_ready held 0 for 5 cycles in RESP -> r0_resp_valid and r0_result stable, alu_enable 0, r1_ready 0, busy 1.
REQ-035 RST asserted during CAPTURE -> next edge all outputs 0, state IDLE, no resp_valid; subsequent r1 op 011 x=00F0 y=000F returns 00FF.
